gmii_rx_framer: RTL and testbench

Consumes the GMII receive stream produced by the RGMII interface block (rxd/rxdv/rxer, clocked by its user clock). It strips preamble/SFD, removes and checks the 4-byte FCS (CRC-32), and applies length checks. Frames are delivered as a byte stream with last/error flags to the MAC receive buffer. It also maintains saturating per-frame statistics counters. There is no backpressure because the output runs at line rate.

---
 rtl/gmii_pkg.sv | 11 +
 rtl/gmii_rx_framer_if.sv | 13 +
 rtl/crc32_d8.sv | 17 +
 rtl/gmii_rx_framer.sv | 146 ++++++++++++++
 tb/tb_gmii_rx_framer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gmii_pkg.sv
// Shared GMII receive-path constants: framing bytes, CRC-32 parameters and framer states.
package gmii_pkg;
  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          DLY_DEPTH   = 5;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} rx_state_e;
endpackage

// File: rtl/gmii_rx_framer_if.sv
// GMII receive input plus the framed byte stream towards the MAC receive buffer.
interface gmii_rx_framer_if;
  logic [7:0] rxd;
  logic       rxdv;
  logic       rxer;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_err;

  modport master (output rxd, rxdv, rxer, input out_data, out_valid, out_last, out_err);
  modport slave  (input rxd, rxdv, rxer, output out_data, out_valid, out_last, out_err);
endinterface

// File: rtl/crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC-32 (no final inversion).
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] w_c;

  always_comb begin
    w_c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    crc_out = w_c;
  end
endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, holds back the FCS through a 5-byte
// delay line, checks CRC/length and keeps saturating per-frame statistics.
module gmii_rx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  gmii_rx_framer_if.slave   gm,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  crc_err_cnt,
  output logic [CNT_W-1:0]  runt_cnt,
  output logic [CNT_W-1:0]  over_cnt,
  output logic [CNT_W-1:0]  align_err_cnt
);
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] L_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] L_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] L_HOLD = LEN_W'(DLY_DEPTH);
  localparam int C_GOOD = 0, C_CRC = 1, C_RUNT = 2, C_OVER = 3, C_ALIGN = 4;

  rx_state_e                     r_state, w_nxt;
  logic                          r_armed, w_arm;
  logic [LEN_W-1:0]              r_len;
  logic [31:0]                   r_crc, w_crc;
  logic                          r_err;
  logic [DLY_DEPTH-1:0][7:0]     r_dly;
  logic [7:0]                    r_data;
  logic                          r_valid, r_last, r_oerr;
  logic [4:0][CNT_W-1:0]         r_cnt;
  logic                          w_emit, w_last, w_err, w_push, w_clr, w_crc_bad;
  logic [4:0]                    w_inc;

  crc32_d8 u_crc (.crc_in(r_crc), .data(gm.rxd), .crc_out(w_crc));

  assign w_crc_bad = (r_crc != CRC_RESIDUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // One counter per frame: oversize beats runt, runt beats crc/rxer.
  always_comb begin
    w_nxt  = r_state;
    w_arm  = r_armed;
    w_emit = 1'b0;
    w_last = 1'b0;
    w_err  = 1'b0;
    w_push = 1'b0;
    w_clr  = 1'b0;
    w_inc  = '0;
    case (r_state)
      S_IDLE: begin
        if (!r_armed) begin
          if (!gm.rxdv) w_arm = 1'b1;
        end else if (gm.rxdv) begin
          if (gm.rxd == PREAMBLE) w_nxt = S_PRE;
          else begin w_nxt = S_DROP; w_inc[C_ALIGN] = 1'b1; end
        end
      end
      S_PRE: begin
        if (!gm.rxdv) begin
          w_nxt = S_IDLE; w_inc[C_ALIGN] = 1'b1;
        end else if (gm.rxd == SFD) begin
          w_nxt = S_DATA; w_clr = 1'b1;
        end else if (gm.rxd != PREAMBLE) begin
          w_nxt = S_DROP; w_inc[C_ALIGN] = 1'b1;
        end
      end
      S_DATA: begin
        if (!gm.rxdv) begin
          w_nxt = S_IDLE;
          if (r_len < L_HOLD) begin
            w_inc[C_RUNT] = 1'b1;
          end else begin
            w_emit = 1'b1;
            w_last = 1'b1;
            w_err  = r_err | w_crc_bad | (r_len < L_MIN);
            if (r_len < L_MIN)         w_inc[C_RUNT] = 1'b1;
            else if (r_err | w_crc_bad) w_inc[C_CRC]  = 1'b1;
            else                        w_inc[C_GOOD] = 1'b1;
          end
        end else if (r_len == L_MAX) begin
          w_nxt  = S_DROP;
          w_emit = 1'b1;
          w_last = 1'b1;
          w_err  = 1'b1;
          w_inc[C_OVER] = 1'b1;
        end else begin
          w_push = 1'b1;
          w_emit = (r_len >= L_HOLD);
        end
      end
      S_DROP: if (!gm.rxdv) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_len   <= '0;
      r_crc   <= CRC_INIT;
      r_err   <= 1'b0;
      r_dly   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_oerr  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_armed <= w_arm;
      r_valid <= w_emit;
      r_last  <= w_last;
      r_oerr  <= w_err;
      r_data  <= w_emit ? r_dly[DLY_DEPTH-1] : 8'h00;
      if (w_clr) begin
        r_len <= '0;
        r_crc <= CRC_INIT;
        r_err <= 1'b0;
        r_dly <= '0;
      end else if (w_push) begin
        r_len <= r_len + LEN_W'(1);
        r_crc <= w_crc;
        r_err <= r_err | gm.rxer;
        r_dly <= {r_dly[DLY_DEPTH-2:0], gm.rxd};
      end
      for (int k = 0; k < 5; k++)
        if (w_inc[k] && !(&r_cnt[k])) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
    end
  end

  assign gm.out_data    = r_data;
  assign gm.out_valid   = r_valid;
  assign gm.out_last    = r_last;
  assign gm.out_err     = r_oerr;
  assign good_cnt       = r_cnt[C_GOOD];
  assign crc_err_cnt    = r_cnt[C_CRC];
  assign runt_cnt       = r_cnt[C_RUNT];
  assign over_cnt       = r_cnt[C_OVER];
  assign align_err_cnt  = r_cnt[C_ALIGN];
endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed scenarios for the GMII receive framer with hand-derived expectations.
module tb_gmii_rx_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] good_cnt, crc_err_cnt, runt_cnt, over_cnt, align_err_cnt;

  gmii_rx_framer_if gm();

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .gm(gm),
    .good_cnt(good_cnt), .crc_err_cnt(crc_err_cnt), .runt_cnt(runt_cnt),
    .over_cnt(over_cnt), .align_err_cnt(align_err_cnt)
  );

  always #4 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int t5 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect every beat away from the active edge.
  logic [7:0] rx_q[$];
  int         cyc_q[$];
  int         n_last = 0, last_idx = 0;
  logic       last_err = 1'b0;
  bit         rst_bad = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      if (gm.out_valid || gm.out_last || gm.out_err ||
          (good_cnt | crc_err_cnt | runt_cnt | over_cnt | align_err_cnt) != 0)
        rst_bad = 1'b1;
    end else if (gm.out_valid) begin
      rx_q.push_back(gm.out_data);
      cyc_q.push_back(cyc);
      if (gm.out_last) begin
        n_last++;
        last_err = gm.out_err;
        last_idx = rx_q.size();
      end
    end
  end

  logic [7:0] tx_q[$];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int n, input int seed, input bit fcs);
    logic [31:0] c = 32'hFFFFFFFF;
    tx_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b = 8'(i * 7 + seed);
      tx_q.push_back(b);
      c = crc_upd(c, b);
    end
    if (fcs) begin
      c = ~c;
      for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clk); #1;
    gm.rxd = d; gm.rxdv = dv; gm.rxer = er;
  endtask

  task automatic send(input int er_idx, input int rst_idx);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < tx_q.size(); i++) begin
      drive(tx_q[i], 1'b1, i == er_idx);
      if (i == 5) t5 = cyc;
      if (i == rst_idx) rst_n = 1'b0;
      if (i == rst_idx + 3) rst_n = 1'b1;
    end
    repeat (12) drive(8'h00, 1'b0, 1'b0);
  endtask

  function automatic int data_bad(input int q0, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (q0 + i >= rx_q.size() || rx_q[q0 + i] !== tx_q[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if ({gm.out_valid, gm.out_last, gm.out_err, gm.out_data} !== 11'h0)
      $display("FAIL reset_out: got %b want 0", {gm.out_valid, gm.out_last, gm.out_err, gm.out_data}); else n_pass++;
    n_chk++; if ((good_cnt | crc_err_cnt | runt_cnt | over_cnt | align_err_cnt) !== 32'h0)
      $display("FAIL reset_cnt: got nonzero counter want 0"); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    n_chk++; if (gm.out_valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", gm.out_valid); else n_pass++;
  endtask

  task automatic test_good();
    int q0 = rx_q.size(), l0 = n_last;
    build(60, 3, 1);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 60) $display("FAIL good_beats: got %0d want 60", rx_q.size() - q0); else n_pass++;
    n_chk++; if (data_bad(q0, 60) !== 0) $display("FAIL good_data: got %0d bad bytes want 0", data_bad(q0, 60)); else n_pass++;
    n_chk++; if (n_last - l0 !== 1 || last_idx !== q0 + 60)
      $display("FAIL good_last: got %0d lasts at %0d want 1 at %0d", n_last - l0, last_idx, q0 + 60); else n_pass++;
    n_chk++; if (last_err !== 1'b0) $display("FAIL good_err: got %b want 0", last_err); else n_pass++;
    n_chk++; if (cyc_q.size() <= q0 || cyc_q[q0] !== t5 + 1)
      $display("FAIL good_latency: got first beat at cycle %0d want %0d", (cyc_q.size() > q0) ? cyc_q[q0] : -1, t5 + 1); else n_pass++;
    n_chk++; if (good_cnt !== 32'd1) $display("FAIL good_cnt: got %0d want 1", good_cnt); else n_pass++;
  endtask

  task automatic test_crc_err();
    int q0 = rx_q.size();
    build(60, 9, 1);
    tx_q[10] = tx_q[10] ^ 8'h01;
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 60) $display("FAIL crc_beats: got %0d want 60", rx_q.size() - q0); else n_pass++;
    n_chk++; if (last_err !== 1'b1) $display("FAIL crc_err_flag: got %b want 1", last_err); else n_pass++;
    n_chk++; if (crc_err_cnt !== 32'd1 || good_cnt !== 32'd1)
      $display("FAIL crc_cnt: got crc %0d good %0d want 1 1", crc_err_cnt, good_cnt); else n_pass++;
  endtask

  task automatic test_rxer();
    build(60, 17, 1);
    send(20, -1);
    n_chk++; if (last_err !== 1'b1) $display("FAIL rxer_flag: got %b want 1", last_err); else n_pass++;
    n_chk++; if (crc_err_cnt !== 32'd2 || good_cnt !== 32'd1)
      $display("FAIL rxer_cnt: got crc %0d good %0d want 2 1", crc_err_cnt, good_cnt); else n_pass++;
  endtask

  task automatic test_runt();
    int q0 = rx_q.size();
    build(36, 40, 1);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 36) $display("FAIL runt_beats: got %0d want 36", rx_q.size() - q0); else n_pass++;
    n_chk++; if (last_err !== 1'b1) $display("FAIL runt_flag: got %b want 1", last_err); else n_pass++;
    n_chk++; if (runt_cnt !== 32'd1 || crc_err_cnt !== 32'd2)
      $display("FAIL runt_cnt: got runt %0d crc %0d want 1 2", runt_cnt, crc_err_cnt); else n_pass++;
  endtask

  task automatic test_short();
    int q0 = rx_q.size(), l0 = n_last;
    build(3, 5, 0);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 0 || n_last !== l0)
      $display("FAIL short_beats: got %0d want 0", rx_q.size() - q0); else n_pass++;
    n_chk++; if (runt_cnt !== 32'd2) $display("FAIL short_cnt: got %0d want 2", runt_cnt); else n_pass++;
  endtask

  task automatic test_align();
    int q0 = rx_q.size();
    drive(8'h55, 1'b1, 1'b0); drive(8'h55, 1'b1, 1'b0); drive(8'h12, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0); drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'(i + 1), 1'b1, 1'b0);
    repeat (12) drive(8'h00, 1'b0, 1'b0);
    n_chk++; if (rx_q.size() - q0 !== 0) $display("FAIL align_beats: got %0d want 0", rx_q.size() - q0); else n_pass++;
    n_chk++; if (align_err_cnt !== 32'd1) $display("FAIL align_cnt: got %0d want 1", align_err_cnt); else n_pass++;
    q0 = rx_q.size();
    build(60, 77, 1);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 60 || data_bad(q0, 60) !== 0)
      $display("FAIL align_next_frame: got %0d beats want 60 clean", rx_q.size() - q0); else n_pass++;
    n_chk++; if (good_cnt !== 32'd2) $display("FAIL align_good_cnt: got %0d want 2", good_cnt); else n_pass++;
  endtask

  task automatic test_oversize();
    int q0 = rx_q.size(), l0 = n_last;
    build(1600, 1, 0);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 1514) $display("FAIL over_beats: got %0d want 1514", rx_q.size() - q0); else n_pass++;
    n_chk++; if (data_bad(q0, 1514) !== 0) $display("FAIL over_data: got %0d bad bytes want 0", data_bad(q0, 1514)); else n_pass++;
    n_chk++; if (n_last - l0 !== 1 || last_idx !== q0 + 1514 || last_err !== 1'b1)
      $display("FAIL over_last: got %0d lasts at %0d err %b want 1 at %0d err 1", n_last - l0, last_idx, last_err, q0 + 1514); else n_pass++;
    n_chk++; if (over_cnt !== 32'd1 || runt_cnt !== 32'd2 || crc_err_cnt !== 32'd2)
      $display("FAIL over_cnt: got over %0d runt %0d crc %0d want 1 2 2", over_cnt, runt_cnt, crc_err_cnt); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int l0 = n_last, q0;
    build(60, 55, 1);
    send(-1, 30);
    n_chk++; if (rst_bad !== 1'b0) $display("FAIL midrst_outputs: got nonzero output during reset want 0"); else n_pass++;
    n_chk++; if (n_last - l0 !== 0) $display("FAIL midrst_last: got %0d lasts want 0", n_last - l0); else n_pass++;
    n_chk++; if ((good_cnt | crc_err_cnt | runt_cnt | over_cnt | align_err_cnt) !== 32'h0)
      $display("FAIL midrst_cnt: got good %0d crc %0d runt %0d over %0d align %0d want all 0",
               good_cnt, crc_err_cnt, runt_cnt, over_cnt, align_err_cnt); else n_pass++;
    q0 = rx_q.size();
    build(60, 100, 1);
    send(-1, -1);
    n_chk++; if (rx_q.size() - q0 !== 60 || last_err !== 1'b0)
      $display("FAIL midrst_next: got %0d beats err %b want 60 err 0", rx_q.size() - q0, last_err); else n_pass++;
    n_chk++; if (good_cnt !== 32'd1) $display("FAIL midrst_good_cnt: got %0d want 1", good_cnt); else n_pass++;
  endtask

  initial begin
    gm.rxd = 8'h00; gm.rxdv = 1'b0; gm.rxer = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_good();
    test_crc_err();
    test_rxer();
    test_runt();
    test_short();
    test_align();
    test_oversize();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
